// File: rtl/mdu_sequencer_if.sv
// EX-stage <-> M-extension sequencer bundle: operation request, pipeline hold and result.
// The EX stage is the master; the sequencer is the slave.
interface mdu_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            stall;
    logic            busy;
    logic [XLEN-1:0] result;
    logic            result_valid;

    modport master (
        output start, funct3, rs1, rs2, flush,
        input  stall, busy, result, result_valid
    );

    modport slave (
        input  start, funct3, rs1, rs2, flush,
        output stall, busy, result, result_valid
    );
endinterface

// File: rtl/mdu_sequencer.sv
// RV32M iterative shift-add multiplier / restoring divider; 33-cycle latency, 1 for divide special cases.
// Holds the pipeline through stall while working; the result is a one-cycle pulse with no backpressure.
module mdu_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    mdu_sequencer_if.slave mdu
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state;
    logic [CNT_W-1:0] count;
    logic [2:0]      op;
    logic            neg;
    logic [XLEN-1:0] acc_hi, acc_lo, opb, result_q;

    // Operand decode for the request sitting in EX.
    logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag, special_res;
    logic            div_zero, div_ovf, special;

    always_comb begin
        is_div   = mdu.funct3[2];
        a_sgn    = is_div ? ~mdu.funct3[0] : (mdu.funct3[1:0] == 2'b01 || mdu.funct3[1:0] == 2'b10);
        b_sgn    = is_div ? ~mdu.funct3[0] : (mdu.funct3[1:0] == 2'b01);
        a_neg    = a_sgn & mdu.rs1[XLEN-1];
        b_neg    = b_sgn & mdu.rs2[XLEN-1];
        a_mag    = a_neg ? -mdu.rs1 : mdu.rs1;
        b_mag    = b_neg ? -mdu.rs2 : mdu.rs2;
        div_zero = is_div && (mdu.rs2 == '0);
        div_ovf  = is_div && !mdu.funct3[0] && (mdu.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (mdu.rs2 == '1);
        special  = div_zero | div_ovf;
        // Overflowed DIV returns the dividend itself (0x80000000).
        if (div_zero) special_res = mdu.funct3[1] ? mdu.rs1 : '1;
        else          special_res = mdu.funct3[1] ? '0 : mdu.rs1;
    end

    // One iteration: acc_lo holds the multiplier (mul) or dividend/quotient (div).
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   nxt_hi, nxt_lo, dval, final_res;
    logic [2*XLEN-1:0] prod, prod_c;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb};
        if (op[2]) begin
            if (!div_diff[XLEN]) begin
                nxt_hi = div_diff[XLEN-1:0];
                nxt_lo = {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                nxt_hi = div_shift[XLEN-1:0];
                nxt_lo = {acc_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            nxt_hi = mul_sum[XLEN:1];
            nxt_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
        prod   = {nxt_hi, nxt_lo};
        prod_c = neg ? -prod : prod;
        dval   = op[1] ? nxt_hi : nxt_lo;
        if (op[2])                final_res = neg ? -dval : dval;
        else if (op[1:0] == 2'b00) final_res = prod_c[XLEN-1:0];
        else                      final_res = prod_c[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            op       <= '0;
            neg      <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: if (mdu.start) begin
                    op <= mdu.funct3;
                    if (special) begin
                        result_q <= special_res;
                        state    <= DONE;
                    end else begin
                        state  <= CALC;
                        count  <= '1;
                        neg    <= (is_div && mdu.funct3[1]) ? a_neg : (a_neg ^ b_neg);
                        acc_hi <= '0;
                        acc_lo <= is_div ? a_mag : b_mag;
                        opb    <= is_div ? b_mag : a_mag;
                    end
                end
                CALC: if (mdu.flush) begin
                    state <= IDLE;
                end else begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    if (count == '0) begin
                        result_q <= final_res;
                        state    <= DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mdu.stall        = ((state == IDLE) && mdu.start) || (state == CALC);
    assign mdu.busy         = (state != IDLE);
    assign mdu.result       = result_q;
    assign mdu.result_valid = (state == DONE);
endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: directed RV32M cases, flush/reset interruptions, then random ops.
module tb_mdu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mdu_sequencer_if m ();

    mdu_sequencer #(.XLEN(32), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (m)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          cyc0;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: plain 64-bit arithmetic plus the RISC-V divide corner rules.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] as_, bs_, au, bu, p;
        logic [31:0] r;
        logic ovf;
        as_ = {{32{a[31]}}, a};
        bs_ = {{32{b[31]}}, b};
        au  = {32'd0, a};
        bu  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        r   = '0;
        case (f)
            3'd0: begin p = as_ * bs_; r = p[31:0];  end
            3'd1: begin p = as_ * bs_; r = p[63:32]; end
            3'd2: begin p = as_ * bu;  r = p[63:32]; end
            3'd3: begin p = au * bu;   r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = 32'h8000_0000;
                else begin p = as_ / bs_; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = 32'd0;
                else begin p = as_ % bs_; r = p[31:0]; end
            end
            3'd7: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    // Monitor: every result_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && m.result_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("stray result_valid", {31'd0, m.result_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result", m.result, e.res);
                chk("latency", cyc - e.cyc0, e.lat);
                chk("stall in DONE", {31'd0, m.stall}, 32'd0);
            end
        end
    end

    // Start is held high through DONE, as a stalled EX stage would.
    task automatic do_op_exp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
        exp_t e;
        int   n_stall;
        bit   done;
        n_stall = 0;
        done    = 1'b0;
        @(negedge clk);
        m.start  = 1'b1;
        m.funct3 = f;
        m.rs1    = a;
        m.rs2    = b;
        e.res  = res;
        e.lat  = ref_latency(f, a, b);
        e.cyc0 = cyc;
        sbq.push_back(e);
        #1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (m.stall) n_stall++;
            @(negedge clk);
            if (m.result_valid) done = 1'b1;
        end
        chk("op completes", {31'd0, done}, 32'd1);
        chk("stall cycles", n_stall, e.lat);
        if (!done && sbq.size() > 0) void'(sbq.pop_back());
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        do_op_exp(f, a, b, ref_model(f, a, b));
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        m.start = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    logic [2:0]  dir_f[12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] dir_a[12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] dir_b[12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] dir_r[12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                               32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

    initial begin
        m.start  = 1'b0;
        m.funct3 = 3'd0;
        m.rs1    = 32'd0;
        m.rs2    = 32'd0;
        m.flush  = 1'b0;
        #1;
        chk("reset busy", {31'd0, m.busy}, 32'd0);
        chk("reset result_valid", {31'd0, m.result_valid}, 32'd0);
        chk("reset stall", {31'd0, m.stall}, 32'd0);
        chk("reset result", m.result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_op_exp(dir_f[i], dir_a[i], dir_b[i], dir_r[i]);
            idle(1 + (i % 2));
        end

        // Result register keeps its value while idle.
        do_op_exp(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        idle(4);
        chk("result hold", m.result, 32'hFFFF_FFEB);

        // Flush a DIV at C10 of its run.
        @(negedge clk);
        m.start = 1'b1; m.funct3 = 3'd4; m.rs1 = 32'd1000; m.rs2 = 32'd3;
        repeat (10) @(negedge clk);
        m.flush = 1'b1;
        m.start = 1'b0;
        @(negedge clk);
        chk("flush busy", {31'd0, m.busy}, 32'd0);
        chk("flush stall", {31'd0, m.stall}, 32'd0);
        chk("flush result_valid", {31'd0, m.result_valid}, 32'd0);
        m.flush = 1'b0;
        do_op_exp(3'd0, 32'd3, 32'd4, 32'd12);
        idle(2);

        // Asynchronous reset at C15 of a multiply.
        @(negedge clk);
        m.start = 1'b1; m.funct3 = 3'd3; m.rs1 = 32'h1234_5678; m.rs2 = 32'h9ABC_DEF0;
        repeat (15) @(negedge clk);
        rst = 1'b0;
        m.start = 1'b0;
        #1;
        chk("mid-op reset busy", {31'd0, m.busy}, 32'd0);
        chk("mid-op reset stall", {31'd0, m.stall}, 32'd0);
        chk("mid-op reset result_valid", {31'd0, m.result_valid}, 32'd0);
        chk("mid-op reset result", m.result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom_range(0, 7)), pick(), pick());
            if ($urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 2));
        end
        idle(3);
        chk("scoreboard drained", sbq.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
